dram_read_arbiter: RTL
======================

// Module: dram_read_arbiter
// PURPOSE
//  Shares the single DRAM read channel (dramra address, dramrd data) of Top among N_RD read requesters
//  (i0/i1 fetchers, cache refill).
//  Round-robin grants onto dramra; records each issued requester ID in an in-order tag FIFO.
//  Routes each dramrd beat back to the requester that issued it. Sits between the fetch units and the Top DRAM ports.
// PARAMETERS
//  N_RD       3    number of read requesters (>=2)
//  ADDR_W     32   DRAM address width
//  DATA_W     256  dramrd beat width
//  MAX_OUTST  8    max outstanding reads (tag FIFO depth, power of 2)
// PORTS
//  i_clk            in   1             clock
//  i_rst            in   1             asynchronous active-low reset
//  i_rq_rdy         in   N_RD          per-requester address valid
//  i_rq_addr        in   N_RD*ADDR_W   per-requester address
//  o_rq_ack         out  N_RD          per-requester address accepted
//  o_dramra_rdy     out  1             arbitrated address valid
//  o_dramra_addr    out  ADDR_W        arbitrated address
//  i_dramra_ack     in   1             DRAM accepts address
//  i_dramrd_rdy     in   1             DRAM read beat valid
//  i_dramrd_data    in   DATA_W        DRAM read beat
//  o_dramrd_ack     out  1             read beat consumed
//  o_rs_rdy         out  N_RD          per-requester response valid (one-hot or 0)
//  o_rs_data        out  DATA_W        response data, broadcast = i_dramrd_data
//  i_rs_ack         in   N_RD          per-requester response consumed
//  o_err            out  1             sticky: dramrd beat arrived with no outstanding tag
// BEHAVIOUR
//  - rdy/ack handshake: transfer when rdy&&ack in the same cycle. rdy holds with stable payload until acked.
//    ack may depend combinationally on rdy.
//  - Reset (i_rst=0, async): tag FIFO empty, count=0, rr_ptr=0, lock clear, o_err=0.
//    All rdy/ack outputs 0 while in reset. Outstanding reads are forgotten.
//  - Arbitration: if lock clear, winner = first i_rq_rdy[k] searching from rr_ptr upward, mod N_RD.
//    If lock set, winner = lock_id.
//  - o_dramra_rdy = (any rdy or lock) && count<MAX_OUTST. o_dramra_addr = i_rq_addr[winner], zero-latency mux.
//  - o_rq_ack[k] = (k==winner) && o_dramra_rdy && i_dramra_ack.
//  - Grant held but not accepted (rdy, no ack, or FIFO full): lock<=1, lock_id<=winner.
//    Grant cannot move until transfer.
//  - On address transfer: push winner ID; lock<=0; rr_ptr<=winner+1 (wraps N_RD-1 -> 0).
//  - Full: count==MAX_OUTST blocks o_dramra_rdy, even if a pop occurs the same cycle.
//    No comb path dramrd -> dramra.
//  - Response: o_rs_rdy[k] = i_dramrd_rdy && count!=0 && head==k. o_dramrd_ack = i_rs_ack[head] && o_rs_rdy[head].
//    Pop on dramrd transfer.
//  - Simultaneous push+pop: count unchanged; head/tail both advance (pointers wrap at MAX_OUTST).
//  - i_dramrd_rdy with count==0: o_dramrd_ack=0, o_rs_rdy=0, o_err<=1 (sticky until reset).
//  - Responses are in issue order. A requester stalling its i_rs_ack blocks all responses (head-of-line by design).
// CONFIGURATION
//  DRAM_ARB_STAT_EN defined: adds outputs o_stat_grant[N_RD*32] and o_stat_full_stall[32].
//   - o_stat_grant: per-requester address transfers.
//   - o_stat_full_stall: cycles with a pending request blocked by full.
//   - Saturating, cleared by reset.
//  Undefined: these ports and their counters are absent; all other behaviour is identical.
// STRUCTURE
//  - TauCfg gains N_DRAM_RD, DRAM_OUTST constants and typedef logic [$clog2(N_DRAM_RD)-1:0] dram_rd_tag_t.
//  - Sub-module dram_arb_tag_fifo: MAX_OUTST x dram_rd_tag_t, push/pop/count, full/empty.
//    Registered count; no bypass.
//  - Arbiter, lock and routing logic live in this module.
// TESTING
//  1 Reset: hold i_rst=0 with i_rq_rdy=3'b111 -> all acks/rdys 0. Release -> req0 granted first, then 1, then 2.
//  2 RR fairness: all 3 rdy continuously, dramra_ack=1, responses returned promptly -> grant order 0,1,2,0,1,2.
//    o_stat_grant equal if STAT_EN.
//  3 Lock: req1 rdy, dramra_ack=0 for 5 cycles, req0 raises rdy at cycle 2 -> addr stays req1's.
//    req1 acked first, req0 next.
//  4 Full: issue 8 reads with no dramrd -> o_dramra_rdy=0 on 9th.
//    One dramrd pop -> rdy returns next cycle, never the same cycle.
//  5 Routing: issue order 2,0,2; dramrd beats 0xA,0xB,0xC -> o_rs_rdy one-hot 100,001,100 with matching data.
//    req2 withholding i_rs_ack stalls o_dramrd_ack.
//  6 Error/mid-reset: dramrd_rdy with count 0 -> o_err=1, ack 0.
//    Assert i_rst with 4 outstanding -> count 0 immediately, o_err cleared.

Source files
------------

// File: rtl/dram_read_arbiter_pkg.sv
// Shared configuration for the DRAM read arbiter: default requester count,
// outstanding-read depth, the requester tag type and the round-robin step helper.
package dram_read_arbiter_pkg;

    localparam int N_DRAM_RD  = 3;
    localparam int DRAM_OUTST = 8;

    typedef logic [$clog2(N_DRAM_RD)-1:0] dram_rd_tag_t;

    // Next round-robin start position after requester `id` wins, wrapping at n.
    function automatic int rr_next(input int id, input int n);
        return (id == n - 1) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/dram_arb_tag_fifo.sv
// In-order tag FIFO holding the requester ID of every issued DRAM read.
// Registered occupancy count; full/empty come from the count only, so a pop
// in the same cycle never frees a slot early (no bypass).
module dram_arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [PW:0]             count;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    // Tag storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter sharing the DRAM read-address channel among N_RD
// requesters, with an in-order tag FIFO that steers each read beat back to
// the requester that issued it.
// Optional feature macro: DRAM_ARB_STAT_EN adds saturating grant and
// full-stall counters on o_stat_grant / o_stat_full_stall.
module dram_read_arbiter
    import dram_read_arbiter_pkg::*;
#(
    parameter int N_RD      = N_DRAM_RD,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int MAX_OUTST = DRAM_OUTST
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_RD-1:0]        i_rq_rdy,
    input  logic [N_RD*ADDR_W-1:0] i_rq_addr,
    output logic [N_RD-1:0]        o_rq_ack,
    output logic                   o_dramra_rdy,
    output logic [ADDR_W-1:0]      o_dramra_addr,
    input  logic                   i_dramra_ack,
    input  logic                   i_dramrd_rdy,
    input  logic [DATA_W-1:0]      i_dramrd_data,
    output logic                   o_dramrd_ack,
    output logic [N_RD-1:0]        o_rs_rdy,
    output logic [DATA_W-1:0]      o_rs_data,
    input  logic [N_RD-1:0]        i_rs_ack,
    output logic                   o_err
`ifdef DRAM_ARB_STAT_EN
    ,
    output logic [N_RD*32-1:0]     o_stat_grant,
    output logic [31:0]            o_stat_full_stall
`endif
);
    localparam int TAG_W = $clog2(N_RD);

    logic [TAG_W-1:0] rr_ptr;
    logic             lock;
    logic [TAG_W-1:0] lock_id;
    logic             hi_ok, lo_ok;
    logic [TAG_W-1:0] hi_id, lo_id;
    logic [TAG_W-1:0] win_id;
    logic             any_req;
    logic             ra_xfer;
    logic             rd_xfer;
    logic [TAG_W-1:0] head_id;
    logic             fifo_full;
    logic             fifo_empty;

    // Round-robin search: lowest ready index at/after rr_ptr, else lowest overall.
    always_comb begin
        hi_ok = 1'b0;
        lo_ok = 1'b0;
        hi_id = '0;
        lo_id = '0;
        for (int k = N_RD - 1; k >= 0; k--) begin
            if (i_rq_rdy[k]) begin
                lo_ok = 1'b1;
                lo_id = TAG_W'(k);
                if (TAG_W'(k) >= rr_ptr) begin
                    hi_ok = 1'b1;
                    hi_id = TAG_W'(k);
                end
            end
        end
    end

    // A stalled grant stays with its owner until the address is transferred.
    assign win_id  = lock ? lock_id : (hi_ok ? hi_id : lo_id);
    assign any_req = lo_ok | lock;

    // Zero-latency address mux onto the DRAM address channel.
    always_comb begin
        o_dramra_addr = '0;
        for (int k = 0; k < N_RD; k++) begin
            if (win_id == TAG_W'(k)) o_dramra_addr = i_rq_addr[k*ADDR_W +: ADDR_W];
        end
    end

    // Fullness is the registered count only, so dramrd never reaches dramra combinationally.
    assign o_dramra_rdy = i_rst && any_req && !fifo_full;
    assign ra_xfer      = o_dramra_rdy && i_dramra_ack;

    // Per-requester address acknowledge and response steering by FIFO head.
    always_comb begin
        o_rq_ack = '0;
        o_rs_rdy = '0;
        for (int k = 0; k < N_RD; k++) begin
            o_rq_ack[k] = ra_xfer && (win_id == TAG_W'(k));
            o_rs_rdy[k] = i_rst && i_dramrd_rdy && !fifo_empty && (head_id == TAG_W'(k));
        end
    end

    assign o_dramrd_ack = |(o_rs_rdy & i_rs_ack);
    assign rd_xfer      = o_dramrd_ack;
    assign o_rs_data    = i_dramrd_data;

    // Grant lock and round-robin pointer update.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            lock    <= 1'b0;
            lock_id <= '0;
            rr_ptr  <= '0;
        end else if (ra_xfer) begin
            lock   <= 1'b0;
            rr_ptr <= TAG_W'(rr_next(int'(win_id), N_RD));
        end else if (any_req) begin
            lock    <= 1'b1;
            lock_id <= win_id;
        end
    end

    // Sticky error: a read beat showed up with nothing outstanding.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                         o_err <= 1'b0;
        else if (i_dramrd_rdy && fifo_empty) o_err <= 1'b1;
    end

    dram_arb_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (TAG_W)
    ) u_tag_fifo (
        .clk   (i_clk),
        .rst_n (i_rst),
        .push  (ra_xfer),
        .pop   (rd_xfer),
        .din   (win_id),
        .head  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef DRAM_ARB_STAT_EN
    logic [N_RD-1:0][31:0] stat_grant;
    logic [31:0]           stat_stall;

    // Saturating per-requester grant counts and full-stall cycle count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stat_grant <= '0;
            stat_stall <= '0;
        end else begin
            for (int k = 0; k < N_RD; k++) begin
                if (o_rq_ack[k] && stat_grant[k] != '1) stat_grant[k] <= stat_grant[k] + 32'd1;
            end
            if (any_req && fifo_full && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
        end
    end

    assign o_stat_grant      = stat_grant;
    assign o_stat_full_stall = stat_stall;
`endif

endmodule
